mem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single core-to-memory bus (cCommand/cAddress/cData out, hReady/hSignal/hData back) between two requesters, port 0 being instruction fetch and port 1 load/store. It sits between the requesters and SoftMemory. It latches the winning request, drives it downstream, and routes the acceptance and completion back to the owner. One transaction is outstanding at a time.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one core-to-memory bus.
// Port 0 is instruction fetch and port 1 is load/store; one transaction is outstanding at a time.
module mem_arbiter #(
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CMD_W-1:0]  p0cCommand,
    input  logic [ADDR_W-1:0] p0cAddress,
    input  logic [DATA_W-1:0] p0cData,
    input  logic [CMD_W-1:0]  p1cCommand,
    input  logic [ADDR_W-1:0] p1cAddress,
    input  logic [DATA_W-1:0] p1cData,
    output logic              p0hReady,
    output logic              p0hSignal,
    output logic [DATA_W-1:0] p0hData,
    output logic              p1hReady,
    output logic              p1hSignal,
    output logic [DATA_W-1:0] p1hData,
    output logic [CMD_W-1:0]  cCommand,
    output logic [ADDR_W-1:0] cAddress,
    output logic [DATA_W-1:0] cData,
    input  logic              hReady,
    input  logic              hSignal,
    input  logic [DATA_W-1:0] hData,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              protocolError
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        grant_q, grant_d;
    logic              perr_q, perr_d;
    logic              req0, req1, win;

    assign req0 = (p0cCommand != '0);
    assign req1 = (p1cCommand != '0);
    // On a tie the port that did not own the previous transaction wins.
    assign win  = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        grant_d = grant_q;
        perr_d  = perr_q | (hSignal && (state_q != S_WAIT));
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = win;
                    grant_d = win ? 2'b10 : 2'b01;
                    cmd_d   = win ? p1cCommand : p0cCommand;
                    addr_d  = win ? p1cAddress : p0cAddress;
                    data_d  = win ? p1cData    : p0cData;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hReady) begin
                    cmd_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hSignal) begin
                    last_d  = owner_q;
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cmd_d   = '0;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            grant_q <= 2'b00;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            perr_q  <= perr_d;
        end
    end

    assign cCommand      = cmd_q;
    assign cAddress      = addr_q;
    assign cData         = data_q;
    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign protocolError = perr_q;

    // Responses are combinational so the owner sees acceptance/completion in the memory's cycle.
    assign p0hReady  = (state_q == S_ISSUE) && !owner_q && hReady;
    assign p1hReady  = (state_q == S_ISSUE) &&  owner_q && hReady;
    assign p0hSignal = (state_q == S_WAIT)  && !owner_q && hSignal;
    assign p1hSignal = (state_q == S_WAIT)  &&  owner_q && hSignal;
    assign p0hData   = hData;
    assign p1hData   = hData;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue of expected grants is filled as requests are
// driven and drained as each downstream command appears.
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  p0cCommand = '0, p1cCommand = '0;
    logic [31:0] p0cAddress = '0, p1cAddress = '0, p0cData = '0, p1cData = '0;
    logic        p0hReady, p0hSignal, p1hReady, p1hSignal;
    logic [31:0] p0hData, p1hData;
    logic [3:0]  cCommand;
    logic [31:0] cAddress, cData;
    logic        hReady = 1'b0, hSignal = 1'b0;
    logic [31:0] hData = '0;
    logic [1:0]  grant;
    logic        busy, protocolError;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          port;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.CMD_W(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .p0cCommand(p0cCommand), .p0cAddress(p0cAddress), .p0cData(p0cData),
        .p1cCommand(p1cCommand), .p1cAddress(p1cAddress), .p1cData(p1cData),
        .p0hReady(p0hReady), .p0hSignal(p0hSignal), .p0hData(p0hData),
        .p1hReady(p1hReady), .p1hSignal(p1hSignal), .p1hData(p1hData),
        .cCommand(cCommand), .cAddress(cAddress), .cData(cData),
        .hReady(hReady), .hSignal(hSignal), .hData(hData),
        .grant(grant), .busy(busy), .protocolError(protocolError)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input bit port, input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.port = port; e.cmd = cmd; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic clear_cmd(input bit port);
        if (port) p1cCommand = '0;
        else      p0cCommand = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hReady = 1'b1;
        hSignal = 1'b0;
        #1;
        chk("rst_cCommand", cCommand, 0);
        chk("rst_cAddress", cAddress, 0);
        chk("rst_cData", cData, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", protocolError, 0);
        chk("rst_hready", {p0hReady, p1hReady}, 0);
        step();
        hReady = 1'b0;
        reset = 1'b1;
    endtask

    // Acts as the memory for one transaction: waits for the downstream command, checks it
    // against the scoreboard, then answers with hReady/hSignal after the given delays.
    task automatic serve(input int rdy_dly, input int sig_dly, input logic [31:0] rdata,
                         input bit drop_early, input bit drop, output int lat);
        exp_t e;
        int n;
        n = 0;
        #1;
        while (cCommand == 0 && n < 20) begin
            step(); #1; n++;
        end
        lat = n;
        if (cCommand == 0) begin chk("issue_timeout", 0, 1); return; end
        if (sb.size() == 0) begin chk("sb_empty", 0, 1); return; end
        e = sb.pop_front();
        chk("cCommand", cCommand, e.cmd);
        chk("cAddress", cAddress, e.addr);
        chk("cData", cData, e.data);
        chk("grant", grant, e.port ? 2'b10 : 2'b01);
        chk("busy_issue", busy, 1);
        if (drop_early) clear_cmd(e.port);
        for (int i = 0; i < rdy_dly; i++) begin
            hReady = 1'b0;
            #1;
            chk("cCommand_hold", cCommand, e.cmd);
            chk("hready_early", {p0hReady, p1hReady}, 0);
            step();
        end
        hReady = 1'b1;
        #1;
        chk("owner_hready", {p1hReady, p0hReady}, e.port ? 2'b10 : 2'b01);
        step();
        hReady = 1'b0;
        if (drop) clear_cmd(e.port);
        #1;
        chk("cCommand_cleared", cCommand, 0);
        chk("grant_wait", grant, e.port ? 2'b10 : 2'b01);
        for (int i = 1; i < sig_dly; i++) begin
            chk("hsignal_early", {p0hSignal, p1hSignal}, 0);
            step();
        end
        hSignal = 1'b1;
        hData = rdata;
        #1;
        chk("owner_hsignal", {p1hSignal, p0hSignal}, e.port ? 2'b10 : 2'b01);
        chk("p0hData", p0hData, rdata);
        chk("p1hData", p1hData, rdata);
        step();
        hSignal = 1'b0;
        hData = '0;
        #1;
        chk("busy_done", busy, 0);
        chk("grant_done", grant, 0);
        chk("hsignal_after", {p0hSignal, p1hSignal}, 0);
    endtask

    initial begin
        int lat;
        @(negedge clock);
        do_reset();

        // Lone p0 read.
        p0cCommand = 4'd1; p0cAddress = 32'h100; p0cData = 32'h0;
        push(1'b0, 4'd1, 32'h100, 32'h0);
        serve(0, 2, 32'hCAFEF00D, 1'b0, 1'b1, lat);
        chk("lat_single", lat, 1);
        step(); #1;
        chk("idle_after", busy, 0);

        // Both ports requesting continuously from reset.
        do_reset();
        p0cCommand = 4'd1; p0cAddress = 32'h10; p0cData = 32'hA0;
        p1cCommand = 4'd2; p1cAddress = 32'h20; p1cData = 32'hB0;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 4'd1, 32'h10, 32'hA0);
            push(1'b1, 4'd2, 32'h20, 32'hB0);
        end
        for (int i = 0; i < 4; i++) begin
            serve(0, 1, 32'h1000 + i, 1'b0, 1'b0, lat);
            chk("lat_b2b", lat, 1);
        end
        p1cCommand = '0;

        // Memory stalls hReady for 5 cycles.
        p0cCommand = 4'd3; p0cAddress = 32'h300; p0cData = 32'h33;
        push(1'b0, 4'd3, 32'h300, 32'h33);
        serve(5, 1, 32'h5555AAAA, 1'b0, 1'b1, lat);

        // Stray hSignal while idle.
        step();
        hSignal = 1'b1;
        #1;
        chk("stray_no_signal", {p0hSignal, p1hSignal}, 0);
        step();
        hSignal = 1'b0;
        #1;
        chk("perr_set", protocolError, 1);
        chk("stray_idle", busy, 0);
        step(); step(); #1;
        chk("perr_sticky", protocolError, 1);

        // Reset in the middle of a p1 WAIT.
        do_reset();
        p1cCommand = 4'd4; p1cAddress = 32'h400; p1cData = 32'h44;
        step(); #1;
        chk("p1_grant", grant, 2'b10);
        hReady = 1'b1;
        step();
        hReady = 1'b0;
        p1cCommand = '0;
        #1;
        chk("p1_in_wait", {busy, cCommand}, {1'b1, 4'd0});
        #2;
        reset = 1'b0;
        #1;
        chk("async_cCommand", cCommand, 0);
        chk("async_grant", grant, 0);
        chk("async_busy", busy, 0);
        @(negedge clock);
        p0cCommand = 4'd5; p0cAddress = 32'h500; p0cData = 32'h55;
        p1cCommand = 4'd6; p1cAddress = 32'h600; p1cData = 32'h66;
        reset = 1'b1;
        push(1'b0, 4'd5, 32'h500, 32'h55);
        push(1'b1, 4'd6, 32'h600, 32'h66);
        serve(0, 1, 32'h11, 1'b0, 1'b1, lat);
        serve(0, 1, 32'h22, 1'b0, 1'b1, lat);

        // p1 withdraws its command in ISSUE before hReady.
        p1cCommand = 4'd7; p1cAddress = 32'h700; p1cData = 32'h77;
        push(1'b1, 4'd7, 32'h700, 32'h77);
        serve(2, 1, 32'h77777777, 1'b1, 1'b0, lat);
        p0cCommand = 4'd8; p0cAddress = 32'h800; p0cData = 32'h88;
        p1cCommand = 4'd9; p1cAddress = 32'h900; p1cData = 32'h99;
        push(1'b0, 4'd8, 32'h800, 32'h88);
        push(1'b1, 4'd9, 32'h900, 32'h99);
        serve(0, 1, 32'h8, 1'b0, 1'b1, lat);
        serve(1, 2, 32'h9, 1'b0, 1'b1, lat);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
